// File: rtl/axis_delay_line_pkg.sv
// Shared types and helpers for the multi-lane AXI-Stream delay line.
//   lane_state_e : per-lane refill state (FILL masks output data, RUN passes it)
//   clamp_delay  : limits a requested delay to the memory depth
// Optional feature macro used by the top level: AXIS_DELAY_LINE_TLAST_EN.
package axis_delay_line_pkg;

    localparam int unsigned DEF_TDATA_WIDTH = 16;
    localparam int unsigned DEF_N_CH        = 4;
    localparam int unsigned DEF_DEPTH       = 64;
    localparam int unsigned DEF_ADDR_W      = $clog2(DEF_DEPTH);

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } lane_state_e;

    // Requested delays above the memory depth behave as the full depth.
    function automatic int unsigned clamp_delay(input int unsigned d, input int unsigned depth);
        return (d > depth) ? depth : d;
    endfunction

endpackage

// File: rtl/axis_delay_lane.sv
// One lane of the delay line: circular sample memory, fill counter and the
// FILL/RUN state machine that zero-masks data until the lane holds enough history.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   accept_i    : beat accepted this cycle (shared handshake, already gated by reset)
//   wptr_i      : shared write pointer
//   din_i       : this lane's input sample
//   delay_i     : requested delay in beats (clamped internally)
//   dout_c_o    : combinational delayed/masked sample for the output register
//   filled_o    : lane is in RUN (output data genuine)
module axis_delay_lane
    import axis_delay_line_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned DELAY_W     = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   accept_i,
    input  logic [$clog2(DEPTH)-1:0] wptr_i,
    input  logic [TDATA_WIDTH-1:0] din_i,
    input  logic [DELAY_W-1:0]     delay_i,
    output logic [TDATA_WIDTH-1:0] dout_c_o,
    output logic                   filled_o
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);

    logic [TDATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DELAY_W-1:0] d_c;
    logic [DELAY_W-1:0] d_q;
    logic               change_c;
    logic [ADDR_W-1:0]  rd_addr_c;
    logic [TDATA_WIDTH-1:0] rd_c;
    logic               genuine_c;

    lane_state_e        state_q, state_d;
    logic [DELAY_W-1:0] cnt_q, cnt_d;

    assign d_c      = DELAY_W'(clamp_delay(32'(delay_i), DEPTH));
    assign change_c = (d_c != d_q);

    // A delay of DEPTH truncates to offset 0: reads the slot about to be overwritten.
    assign rd_addr_c = wptr_i - d_c[ADDR_W-1:0];
    assign rd_c      = (d_c == '0) ? din_i : mem_q[rd_addr_c];

    // A beat arriving on a delay change belongs to the new refill, so it is masked.
    assign genuine_c = (d_c == '0) || ((state_q == RUN) && !change_c);
    assign dout_c_o  = genuine_c ? rd_c : '0;
    assign filled_o  = (state_q == RUN);

    // Sample memory: written on accept, intentionally not reset.
    always_ff @(posedge clk) begin
        if (accept_i) begin
            mem_q[wptr_i] <= din_i;
        end
    end

    // State, fill counter and last-seen delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FILL;
            cnt_q   <= '0;
            d_q     <= d_c;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_c;
        end
    end

    // Refill control: a delay change restarts the count; a zero delay lands in RUN at once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (change_c) begin
            cnt_d = accept_i ? DELAY_W'(1) : '0;
        end else if ((state_q == FILL) && accept_i && (cnt_q < DELAY_W'(DEPTH))) begin
            cnt_d = cnt_q + DELAY_W'(1);
        end
        if (change_c || (state_q == FILL)) begin
            state_d = (cnt_d >= d_c) ? RUN : FILL;
        end
    end

endmodule

// File: rtl/axis_delay_line.sv
// Multi-lane AXI-Stream delay line. Each lane delays its data by a per-lane
// number of accepted beats; lanes zero-mask their output while refilling.
// Optional tlast pass-through (undelayed, travels with its own beat) is enabled
// by defining AXIS_DELAY_LINE_TLAST_EN.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   s_axis_*        : input stream (tdata lanes packed, tvalid, tready comb)
//   m_axis_*        : output stream from a single register stage
//   delay           : per-lane delay in beats, DELAY_W bits per lane
//   lane_filled     : per-lane RUN indication
//   s/m_axis_tlast  : only with AXIS_DELAY_LINE_TLAST_EN
module axis_delay_line
    import axis_delay_line_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int unsigned N_CH        = DEF_N_CH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned DELAY_W     = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_CH*TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
`ifdef AXIS_DELAY_LINE_TLAST_EN
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tlast,
`endif
    output logic [N_CH*TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    input  logic [N_CH*DELAY_W-1:0]       delay,
    output logic [N_CH-1:0]               lane_filled
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BUS_W  = N_CH * TDATA_WIDTH;

    logic [ADDR_W-1:0] wptr_q, wptr_d;
    logic [BUS_W-1:0]  m_tdata_q, m_tdata_d;
    logic              m_tvalid_q, m_tvalid_d;
`ifdef AXIS_DELAY_LINE_TLAST_EN
    logic              m_tlast_q, m_tlast_d;
`endif

    logic              accept_c;
    logic              lane_accept_c;
    logic [BUS_W-1:0]  lane_dout_c;

    // Single output register: new beat may enter when it is empty or draining.
    assign s_axis_tready = !m_tvalid_q || m_axis_tready;
    assign accept_c      = s_axis_tvalid && s_axis_tready;
    // Beats offered during reset are discarded, including their memory write.
    assign lane_accept_c = accept_c && !reset;

    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
`ifdef AXIS_DELAY_LINE_TLAST_EN
    assign m_axis_tlast  = m_tlast_q;
`endif

    for (genvar k = 0; k < N_CH; k++) begin : g_lane
        axis_delay_lane #(
            .TDATA_WIDTH (TDATA_WIDTH),
            .DEPTH       (DEPTH),
            .DELAY_W     (DELAY_W)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .accept_i (lane_accept_c),
            .wptr_i   (wptr_q),
            .din_i    (s_axis_tdata[k*TDATA_WIDTH +: TDATA_WIDTH]),
            .delay_i  (delay[k*DELAY_W +: DELAY_W]),
            .dout_c_o (lane_dout_c[k*TDATA_WIDTH +: TDATA_WIDTH]),
            .filled_o (lane_filled[k])
        );
    end

    // Write pointer and output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
`ifdef AXIS_DELAY_LINE_TLAST_EN
            m_tlast_q  <= 1'b0;
`endif
        end else begin
            wptr_q     <= wptr_d;
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
`ifdef AXIS_DELAY_LINE_TLAST_EN
            m_tlast_q  <= m_tlast_d;
`endif
        end
    end

    // Pointer advances and the output stage loads only on an accepted beat.
    always_comb begin
        wptr_d     = wptr_q;
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
`ifdef AXIS_DELAY_LINE_TLAST_EN
        m_tlast_d  = m_tlast_q;
`endif
        if (accept_c) begin
            wptr_d     = wptr_q + ADDR_W'(1);
            m_tdata_d  = lane_dout_c;
            m_tvalid_d = 1'b1;
`ifdef AXIS_DELAY_LINE_TLAST_EN
            // tlast marks the frame edge of this beat, not of the delayed data.
            m_tlast_d  = s_axis_tlast;
`endif
        end else if (m_axis_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_delay_line.sv
// Self-checking bench for axis_delay_line with a beat-history reference model.
module tb_axis_delay_line;

    localparam int unsigned TW  = 16;
    localparam int unsigned NCH = 4;
    localparam int unsigned DEP = 64;
    localparam int unsigned DLW = $clog2(DEP + 1);
    localparam int unsigned BW  = NCH * TW;

    logic              clk;
    logic              reset;
    logic [BW-1:0]     s_tdata;
    logic              s_tvalid;
    logic              s_tready;
    logic [BW-1:0]     m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic [NCH*DLW-1:0] delay;
    logic [NCH-1:0]    lane_filled;
`ifdef AXIS_DELAY_LINE_TLAST_EN
    logic              s_tlast;
    logic              m_tlast;
`endif

    int checks = 0;
    int errors = 0;
    int beat_no = 0;

    // Reference model state: expected output register and per-lane refill progress.
    logic          exp_vld;
    logic [BW-1:0] exp_data;
    logic [NCH-1:0] exp_filled;
    int            fcnt   [NCH];
    int            prev_d [NCH];
    logic [BW-1:0] hist [$];

    logic [BW+NCH+1:0] obs, req;

    axis_delay_line #(
        .TDATA_WIDTH (TW),
        .N_CH        (NCH),
        .DEPTH       (DEP),
        .DELAY_W     (DLW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
`ifdef AXIS_DELAY_LINE_TLAST_EN
        .s_axis_tlast  (s_tlast),
        .m_axis_tlast  (m_tlast),
`endif
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .delay         (delay),
        .lane_filled   (lane_filled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lane_delay(input int k);
        int v;
        v = int'(delay[k*DLW +: DLW]);
        return (v > int'(DEP)) ? int'(DEP) : v;
    endfunction

    task automatic set_delay(input int k, input int v);
        delay[k*DLW +: DLW] = DLW'(v);
    endtask

    task automatic drive_ramp();
        beat_no++;
        for (int k = 0; k < NCH; k++) begin
            s_tdata[k*TW +: TW] = TW'((k << 12) | (beat_no & 12'hfff));
        end
    endtask

    // Update the model for the coming clock edge, then step past that edge.
    task automatic advance();
        logic          acc;
        int            d;
        int            n;
        logic [BW-1:0] h;
        logic [TW-1:0] o;
        acc = s_tvalid && (!exp_vld || m_tready);
        if (reset) begin
            exp_vld    = 1'b0;
            exp_data   = '0;
            exp_filled = '0;
            hist.delete();
            for (int k = 0; k < NCH; k++) begin
                fcnt[k]   = 0;
                prev_d[k] = lane_delay(k);
            end
        end else begin
            n = hist.size();
            for (int k = 0; k < NCH; k++) begin
                d = lane_delay(k);
                if (d != prev_d[k]) fcnt[k] = 0;
                if (acc) begin
                    if (d == 0) begin
                        o = s_tdata[k*TW +: TW];
                    end else if (fcnt[k] >= d) begin
                        h = hist[n-d];
                        o = h[k*TW +: TW];
                    end else begin
                        o = '0;
                    end
                    exp_data[k*TW +: TW] = o;
                    fcnt[k]++;
                end
                exp_filled[k] = (fcnt[k] >= d);
                prev_d[k]     = d;
            end
            if (acc) begin
                hist.push_back(s_tdata);
                exp_vld = 1'b1;
            end else if (m_tready) begin
                exp_vld = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_delay(0, 0); set_delay(1, 1); set_delay(2, 5); set_delay(3, 64);
        advance();
        advance();
        checks++;
        if (m_tvalid !== 1'b0) begin
            errors++; $display("FAIL reset_tvalid got %b exp 0", m_tvalid);
        end
        checks++;
        if (m_tdata !== '0) begin
            errors++; $display("FAIL reset_tdata got %h exp 0", m_tdata);
        end
        checks++;
        if (lane_filled !== '0) begin
            errors++; $display("FAIL reset_filled got %b exp 0", lane_filled);
        end
    endtask

    task automatic test_ramp();
        reset = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            drive_ramp();
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL ramp i=%0d got %h exp %h", i, obs, req);
            end
            if (i == 6) begin
                checks++;
                if (m_tdata[2*TW +: TW] !== 16'h2001) begin
                    errors++; $display("FAIL ramp_lane2_first got %h exp 2001", m_tdata[2*TW +: TW]);
                end
            end
            advance();
        end
        checks++;
        if (lane_filled !== {NCH{1'b1}}) begin
            errors++; $display("FAIL ramp_all_filled got %b exp 1111", lane_filled);
        end
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < NCH; k++) set_delay(k, 3);
        for (int i = 0; i < 300; i++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            m_tready = 1'($urandom_range(0, 1));
            s_tdata  = {$urandom, $urandom};
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL backpressure i=%0d got %h exp %h", i, obs, req);
            end
            advance();
        end
    endtask

    task automatic test_delay_change();
        int zeros;
        zeros = 0;
        for (int k = 0; k < NCH; k++) set_delay(k, 4);
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (i == 20) set_delay(1, 2);
            drive_ramp();
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL delay_change i=%0d got %h exp %h", i, obs, req);
            end
            if (i >= 20 && m_tvalid && m_tdata[TW +: TW] == '0) zeros++;
            advance();
        end
        checks++;
        if (zeros != 2) begin
            errors++; $display("FAIL delay_change_masked got %0d exp 2", zeros);
        end
    endtask

    task automatic test_clamp();
        set_delay(0, 100); set_delay(1, 127); set_delay(2, 64); set_delay(3, 7);
        s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 140; i++) begin
            drive_ramp();
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL clamp i=%0d got %h exp %h", i, obs, req);
            end
            advance();
        end
        // Clamped lanes must carry the same beat as the lane at full depth.
        checks++;
        if (m_tdata[0 +: 12] !== m_tdata[2*TW +: 12] || m_tdata[0 +: 12] == 12'h0) begin
            errors++; $display("FAIL clamp_align got %h exp %h", m_tdata[0 +: 12], m_tdata[2*TW +: 12]);
        end
        // Delay change coincident with an accept: that beat is the first of three.
        set_delay(3, 3);
        drive_ramp();
        advance();
        checks++;
        if (lane_filled[3] !== 1'b0) begin
            errors++; $display("FAIL same_cycle_fill1 got %b exp 0", lane_filled[3]);
        end
        for (int i = 0; i < 2; i++) begin
            drive_ramp();
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL same_cycle i=%0d got %h exp %h", i, obs, req);
            end
            advance();
        end
        checks++;
        if (lane_filled[3] !== 1'b1) begin
            errors++; $display("FAIL same_cycle_fill3 got %b exp 1", lane_filled[3]);
        end
    endtask

    task automatic test_reset_mid();
        s_tvalid = 1'b1; m_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_ramp();
            advance();
        end
        reset = 1'b1;
        advance();
        checks++;
        if (m_tvalid !== 1'b0 || m_tdata !== '0 || lane_filled !== '0) begin
            errors++; $display("FAIL reset_mid got v=%b d=%h f=%b exp 0", m_tvalid, m_tdata, lane_filled);
        end
        reset = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_ramp();
            #1;
            obs = {m_tvalid, s_tready, lane_filled, exp_vld ? m_tdata : BW'(0)};
            req = {exp_vld, !exp_vld || m_tready, exp_filled, exp_vld ? exp_data : BW'(0)};
            checks++;
            if (obs !== req) begin
                errors++; $display("FAIL reset_refill i=%0d got %h exp %h", i, obs, req);
            end
            advance();
        end
        checks++;
        if (lane_filled !== 4'b1000) begin
            errors++; $display("FAIL reset_refill_filled got %b exp 1000", lane_filled);
        end
    endtask

`ifdef AXIS_DELAY_LINE_TLAST_EN
    task automatic test_tlast();
        int outn;
        outn = 0;
        reset = 1'b1;
        for (int k = 0; k < NCH; k++) set_delay(k, 3);
        advance();
        reset = 1'b0; s_tvalid = 1'b1; m_tready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            drive_ramp();
            s_tlast = ((i + 1) % 8 == 0);
            #1;
            if (m_tvalid) begin
                outn++;
                checks++;
                if (m_tlast !== 1'((outn % 8) == 0)) begin
                    errors++; $display("FAIL tlast beat=%0d got %b exp %b", outn, m_tlast, (outn % 8) == 0);
                end
            end
            advance();
        end
        s_tlast = 1'b0;
    endtask
`endif

    initial begin
        reset    = 1'b1;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        s_tdata  = '0;
        delay    = '0;
`ifdef AXIS_DELAY_LINE_TLAST_EN
        s_tlast  = 1'b0;
`endif
        test_reset();
        test_ramp();
        test_backpressure();
        test_delay_change();
        test_clamp();
        test_reset_mid();
`ifdef AXIS_DELAY_LINE_TLAST_EN
        test_tlast();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
